// File: rtl/kernel_prueba_pkg.sv
// Shared types and constants for the kernel_prueba chunk scheduler.
package kernel_prueba_pkg;

    // Sequencer states: wait for a start, fire one engine run, wait for it, report completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The host expresses job length in 32-bit words; the engine works in bytes.
    localparam int LP_BYTES_PER_WORD = 4;

    // Largest byte count handed to the engine in a single run unless overridden.
    localparam int LP_DEFAULT_MAX_CHUNK_BYTES = 4096;

endpackage : kernel_prueba_pkg

// File: rtl/kernel_prueba_ap_ctrl.sv
// Host-side ap_ctrl handshake: start edge detection, the ap_idle flag and the
// ap_done/ap_ready pulse derived from the sequencer's done request.
module kernel_prueba_ap_ctrl
    import kernel_prueba_pkg::*;
(
    input  logic ap_clk,
    input  logic areset,
    input  logic ap_start,
    input  logic start_accept,
    input  logic done_req,
    output logic start_pulse,
    output logic ap_idle,
    output logic ap_done,
    output logic ap_ready
);

    logic ap_start_q;

    // Previous ap_start level; cleared in reset so a start held across reset release reads as an edge.
    always_ff @(posedge ap_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (areset) begin
            ap_start_q <= 1'b0;
        end else begin
            ap_start_q <= ap_start;
        end
    end

    assign start_pulse = ap_start & ~ap_start_q;

    // ap_idle drops the cycle after an accepted start and rises the cycle after the done pulse.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            ap_idle <= 1'b1;
        end else if (done_req) begin
            ap_idle <= 1'b1;
        end else if (start_pulse && start_accept) begin
            ap_idle <= 1'b0;
        end
    end

    // The done request already lasts exactly one cycle, so it is the pulse itself.
    assign ap_done  = done_req;
    assign ap_ready = done_req;

endmodule : kernel_prueba_ap_ctrl

// File: rtl/kernel_prueba_chunk_sched.sv
// Chunk scheduler: latches a job on an ap_start edge, splits it into engine runs of
// at most C_MAX_CHUNK_BYTES, advances the address per run and reports completion.
module kernel_prueba_chunk_sched
    import kernel_prueba_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_CHUNK_BYTES = LP_DEFAULT_MAX_CHUNK_BYTES
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [31:0]                  in1,
    input  logic [31:0]                  in2,
    input  logic [C_ADDR_WIDTH-1:0]      base_addr,
    output logic                         eng_start,
    output logic [C_ADDR_WIDTH-1:0]      eng_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size_in_bytes,
    output logic [31:0]                  eng_constant,
    input  logic                         eng_done,
    output logic [C_XFER_SIZE_WIDTH-1:0] chunk_count
);

    // A chunk size that is not a whole number of words would leave the engine mid-word.
    if ((C_MAX_CHUNK_BYTES < LP_BYTES_PER_WORD) ||
        ((C_MAX_CHUNK_BYTES % LP_BYTES_PER_WORD) != 0)) begin : g_bad_chunk
        $error("C_MAX_CHUNK_BYTES must be a multiple of 4 and at least 4");
    end

    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_MAX_CHUNK = C_XFER_SIZE_WIDTH'(C_MAX_CHUNK_BYTES);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_ONE       = C_XFER_SIZE_WIDTH'(1);

    state_t                         state;
    state_t                         state_nxt;
    logic [C_XFER_SIZE_WIDTH-1:0]   remaining_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   rem_after_chunk;
    logic [C_XFER_SIZE_WIDTH-1:0]   len_bytes;
    logic [C_ADDR_WIDTH-1:0]        offset_q;
    logic                           start_pulse;
    logic                           start_accept;
    logic                           done_req;

    // The two top bits of the word count would overflow the byte count and are dropped.
    logic unused_in1_hi;
    assign unused_in1_hi = &{1'b0, in1[31:30]};

    // Clamp a remaining byte count to the largest run the engine may be given.
    function automatic logic [C_XFER_SIZE_WIDTH-1:0] clamp_chunk(
        input logic [C_XFER_SIZE_WIDTH-1:0] bytes
    );
        return (bytes > LP_MAX_CHUNK) ? LP_MAX_CHUNK : bytes;
    endfunction

    assign len_bytes       = C_XFER_SIZE_WIDTH'({in1[29:0], 2'b00});
    assign rem_after_chunk = remaining_q - eng_xfer_size_in_bytes;
    assign eng_addr_offset = offset_q;

    kernel_prueba_ap_ctrl u_ap_ctrl (
        .ap_clk       (ap_clk),
        .areset       (areset),
        .ap_start     (ap_start),
        .start_accept (start_accept),
        .done_req     (done_req),
        .start_pulse  (start_pulse),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start edges only matter in IDLE, engine completions only in WAIT.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start_pulse) state_nxt = (len_bytes == '0) ? DONE : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (eng_done) state_nxt = (rem_after_chunk == '0) ? DONE : LAUNCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: single-cycle engine start and done request straight from the state.
    always_comb begin
        eng_start    = (state == LAUNCH);
        done_req     = (state == DONE);
        start_accept = (state == IDLE);
    end

    // Job datapath: latch the job on an accepted start, step address and counters per completed chunk.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            remaining_q            <= '0;
            offset_q               <= '0;
            eng_constant           <= '0;
            chunk_count            <= '0;
            eng_xfer_size_in_bytes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        remaining_q            <= len_bytes;
                        offset_q               <= base_addr;
                        eng_constant           <= in2;
                        chunk_count            <= '0;
                        eng_xfer_size_in_bytes <= clamp_chunk(len_bytes);
                    end
                end
                WAIT: begin
                    // Updates land after the last WAIT cycle, so eng_* stay stable while the engine runs.
                    if (eng_done) begin
                        remaining_q <= rem_after_chunk;
                        offset_q    <= offset_q + C_ADDR_WIDTH'(eng_xfer_size_in_bytes);
                        chunk_count <= chunk_count + LP_ONE;
                        if (rem_after_chunk != '0) begin
                            eng_xfer_size_in_bytes <= clamp_chunk(rem_after_chunk);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : kernel_prueba_chunk_sched

// File: tb/tb_kernel_prueba_chunk_sched.sv
// Self-checking bench for kernel_prueba_chunk_sched: table-driven jobs, an engine
// responder, a chunk scoreboard and hand-written corner-case sequences.
module tb_kernel_prueba_chunk_sched;

    localparam int MAX_CHUNK = 4096;
    localparam int ENG_LAT   = 20;
    localparam int DONE_WAIT = 2000;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [63:0] base;
        int          exp_chunks;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] size;
        logic [31:0] cnst;
    } chunk_t;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [63:0] base_addr;
    logic        eng_start;
    logic [63:0] eng_addr_offset;
    logic [31:0] eng_xfer_size_in_bytes;
    logic [31:0] eng_constant;
    logic        eng_done;
    logic [31:0] chunk_count;

    logic        eng_done_model = 1'b0;
    logic        eng_done_inj   = 1'b0;
    int          eng_cnt        = 0;

    int          checks     = 0;
    int          errors     = 0;
    int          done_count = 0;
    int          start_count = 0;
    chunk_t      sb_q[$];
    vec_t        vecs[7];

    assign eng_done = eng_done_model | eng_done_inj;

    always #5 ap_clk = ~ap_clk;

    kernel_prueba_chunk_sched #(
        .C_ADDR_WIDTH      (64),
        .C_XFER_SIZE_WIDTH (32),
        .C_MAX_CHUNK_BYTES (MAX_CHUNK)
    ) dut (
        .ap_clk                 (ap_clk),
        .areset                 (areset),
        .ap_start               (ap_start),
        .ap_idle                (ap_idle),
        .ap_done                (ap_done),
        .ap_ready               (ap_ready),
        .in1                    (in1),
        .in2                    (in2),
        .base_addr              (base_addr),
        .eng_start              (eng_start),
        .eng_addr_offset        (eng_addr_offset),
        .eng_xfer_size_in_bytes (eng_xfer_size_in_bytes),
        .eng_constant           (eng_constant),
        .eng_done               (eng_done),
        .chunk_count            (chunk_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected chunk list for a job, pushed before the start is driven.
    task automatic push_job(input logic [31:0] j_in1, input logic [31:0] j_in2, input logic [63:0] j_base);
        logic [31:0] rem;
        logic [31:0] sz;
        logic [63:0] off;
        rem = {j_in1[29:0], 2'b00};
        off = j_base;
        while (rem != 0) begin
            sz = (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
            sb_q.push_back('{off, sz, j_in2});
            off = off + 64'(sz);
            rem = rem - sz;
        end
    endtask

    // Monitor + engine responder, one block so the done history is read before it is updated.
    always @(negedge ap_clk) begin
        chunk_t e;
        if (eng_start) begin
            start_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_eng_start: got addr %0h size %0h expected none", eng_addr_offset, eng_xfer_size_in_bytes);
            end else begin
                e = sb_q.pop_front();
                check("chunk_addr", eng_addr_offset, e.addr);
                check("chunk_size", 64'(eng_xfer_size_in_bytes), 64'(e.size));
                check("chunk_const", 64'(eng_constant), 64'(e.cnst));
            end
        end
        if (eng_done_model && !areset) begin
            check("done_to_next_latency", 64'(eng_start | ap_done), 64'd1);
        end
        if (ap_done) begin
            done_count++;
            check("done_idle_exclusive", 64'(ap_idle), 64'd0);
            check("ap_ready_eq_done", 64'(ap_ready), 64'd1);
        end
        if (areset) begin
            eng_cnt        = 0;
            eng_done_model = 1'b0;
        end else begin
            eng_done_model = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done_model = 1'b1;
            end
            if (eng_start) eng_cnt = ENG_LAT;
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < DONE_WAIT; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ap_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idle"},   64'(ap_idle), 64'd1);
        check({tag, "_done"},   64'(ap_done), 64'd0);
        check({tag, "_ready"},  64'(ap_ready), 64'd0);
        check({tag, "_start"},  64'(eng_start), 64'd0);
        check({tag, "_addr"},   eng_addr_offset, 64'd0);
        check({tag, "_size"},   64'(eng_xfer_size_in_bytes), 64'd0);
        check({tag, "_const"},  64'(eng_constant), 64'd0);
        check({tag, "_chunks"}, 64'(chunk_count), 64'd0);
    endtask

    // One complete job: start edge, latency checks, completion and idle recovery.
    task automatic run_job(input vec_t v);
        bit ok;
        int d0;
        push_job(v.in1, v.in2, v.base);
        d0        = done_count;
        in1       = v.in1;
        in2       = v.in2;
        base_addr = v.base;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        check("first_eng_start_latency", 64'(eng_start), 64'(v.exp_chunks != 0));
        check("zero_len_done_latency", 64'(ap_done), 64'(v.exp_chunks == 0));
        check("idle_cleared", 64'(ap_idle), 64'd0);
        if (ap_done) ok = 1'b1;
        else wait_done(ok);
        if (ok) begin
            check("chunk_count", 64'(chunk_count), 64'(v.exp_chunks));
            check("all_chunks_issued", 64'(sb_q.size()), 64'd0);
            check("eng_constant_latched", 64'(eng_constant), 64'(v.in2));
        end
        ap_start = 1'b0;
        @(negedge ap_clk);
        check("idle_after_done", 64'(ap_idle), 64'd1);
        check("done_one_cycle", 64'(ap_done), 64'd0);
        check("ready_one_cycle", 64'(ap_ready), 64'd0);
        check("done_pulses_per_job", 64'(done_count - d0), 64'd1);
    endtask

    initial begin
        bit ok;
        int d0;
        int s0;

        vecs[0] = '{32'd2048,       32'd7,          64'h1000,                2};
        vecs[1] = '{32'd1500,       32'd9,          64'h4000,                2};
        vecs[2] = '{32'd0,          32'd3,          64'h10,                  0};
        vecs[3] = '{32'd1,          32'hDEADBEEF,   64'h20,                  1};
        vecs[4] = '{32'hC000_0400,  32'd1,          64'h0,                   1};
        vecs[5] = '{32'd2048,       32'd2,          64'hFFFF_FFFF_FFFF_F800, 2};
        vecs[6] = '{32'd3072,       32'd5,          64'h100,                 3};

        areset    = 1'b1;
        ap_start  = 1'b0;
        in1       = '0;
        in2       = '0;
        base_addr = '0;
        repeat (3) @(negedge ap_clk);
        check_reset_outputs("reset");
        areset = 1'b0;
        @(negedge ap_clk);

        // Table-driven jobs.
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
            repeat (2) @(negedge ap_clk);
        end

        // Second start edge and a spurious eng_done during LAUNCH are both ignored.
        push_job(32'd2048, 32'd21, 64'h20000);
        d0        = done_count;
        in1       = 32'd2048;
        in2       = 32'd21;
        base_addr = 64'h20000;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        check("spur_launch_start", 64'(eng_start), 64'd1);
        eng_done_inj = 1'b1;
        ap_start     = 1'b0;
        @(negedge ap_clk);
        eng_done_inj = 1'b0;
        ap_start     = 1'b1;
        in1          = 32'd5;
        in2          = 32'd99;
        wait_done(ok);
        if (ok) begin
            check("spur_chunk_count", 64'(chunk_count), 64'd2);
            check("spur_constant", 64'(eng_constant), 64'd21);
        end
        s0 = start_count;
        repeat (5) @(negedge ap_clk);
        check("spur_no_queued_job", 64'(start_count - s0), 64'd0);
        check("spur_done_pulses", 64'(done_count - d0), 64'd1);
        check("spur_queue_empty", 64'(sb_q.size()), 64'd0);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);

        // ap_start held high across completion: exactly one job, then a fresh edge relaunches.
        push_job(32'd1024, 32'd4, 64'h300);
        d0        = done_count;
        s0        = start_count;
        in1       = 32'd1024;
        in2       = 32'd4;
        base_addr = 64'h300;
        ap_start  = 1'b1;
        repeat (100) @(negedge ap_clk);
        check("held_single_done", 64'(done_count - d0), 64'd1);
        check("held_single_start", 64'(start_count - s0), 64'd1);
        check("held_idle", 64'(ap_idle), 64'd1);
        ap_start = 1'b0;
        @(negedge ap_clk);
        run_job('{32'd2048, 32'd11, 64'h8000, 2});
        repeat (2) @(negedge ap_clk);

        // Reset during the WAIT of chunk 2; ap_start high at release counts as a new edge.
        push_job(32'd2048, 32'd13, 64'h40000);
        d0        = done_count;
        s0        = start_count;
        in1       = 32'd2048;
        in2       = 32'd13;
        base_addr = 64'h40000;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (start_count == s0 + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge ap_clk);
        end
        check("rst_second_chunk_seen", 64'(ok), 64'd1);
        repeat (3) @(negedge ap_clk);
        ap_start  = 1'b1;
        in1       = 32'd512;
        in2       = 32'd77;
        base_addr = 64'h50000;
        areset    = 1'b1;
        @(negedge ap_clk);
        check_reset_outputs("midjob_reset");
        check("midjob_no_done", 64'(done_count - d0), 64'd0);
        check("midjob_queue_empty", 64'(sb_q.size()), 64'd0);
        push_job(32'd512, 32'd77, 64'h50000);
        @(negedge ap_clk);
        areset = 1'b0;
        wait_done(ok);
        if (ok) begin
            check("post_reset_chunk_count", 64'(chunk_count), 64'd1);
            check("post_reset_constant", 64'(eng_constant), 64'd77);
            check("post_reset_queue_empty", 64'(sb_q.size()), 64'd0);
        end
        ap_start = 1'b0;
        @(negedge ap_clk);
        check("post_reset_idle", 64'(ap_idle), 64'd1);
        check("post_reset_done_pulses", 64'(done_count - d0), 64'd1);

        repeat (5) @(negedge ap_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_kernel_prueba_chunk_sched

// File: doc/kernel_prueba_chunk_sched.md
Name: kernel_prueba_chunk_sched

Overview:
- Control sequencer between the host-visible ap_ctrl interface and one vadd engine instance.
- On an ap_start rising edge it latches the transfer length (in1, in 32-bit words), the add constant (in2) and the buffer base address.
- It splits the transfer into chunks of at most C_MAX_CHUNK_BYTES and issues one engine start per chunk, advancing the address each time.
- It raises ap_done once the last chunk completes. This replaces the fixed 16 KiB / constant-1 control path.

Parameters:
C_ADDR_WIDTH, 64, engine and host address width
C_XFER_SIZE_WIDTH, 32, width of byte counts
C_MAX_CHUNK_BYTES, 4096, maximum bytes per engine run; must be a multiple of 4 and ≥4 (elaboration-time assertion)

Ports:
ap_clk  in  1  clock
areset  in  1  synchronous active-high reset
ap_start  in  1  host start, level; only its rising edge is used
ap_idle  out  1  high when no job is active
ap_done  out  1  one-cycle pulse at job completion
ap_ready  out  1  equal to ap_done
in1  in  32  job length in 32-bit words
in2  in  32  add constant
base_addr  in  C_ADDR_WIDTH  buffer base byte address
eng_start  out  1  one-cycle engine start pulse
eng_addr_offset  out  C_ADDR_WIDTH  chunk byte address
eng_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  chunk byte count
eng_constant  out  32  latched in2
eng_done  in  1  engine completion pulse
chunk_count  out  C_XFER_SIZE_WIDTH  number of chunks completed in the current/last job

Behaviour:
- Clock and reset: ap_clk rising edge; areset is synchronous and active-high.
- Reset values: ap_idle=1; ap_done, ap_ready, eng_start=0; eng_addr_offset, eng_xfer_size_in_bytes, eng_constant, chunk_count=0; start-edge register=0; state IDLE.
- Start edge: start_pulse = ap_start & ~ap_start_q, where ap_start_q is a register.
  - If ap_start is already high when reset is released, that counts as an edge.
  - Edges seen outside IDLE are ignored; no queueing.
- States:
  - IDLE: on start_pulse, latch the following, then go to LAUNCH, or to DONE if in1==0:
    - remaining = {in1[29:0],2'b00}; in1[31:30] ignored
    - offset = base_addr
    - eng_constant = in2
    - chunk_count = 0
    - eng_xfer_size_in_bytes = min(remaining, C_MAX_CHUNK_BYTES)
  - LAUNCH: eng_start=1 for exactly this one cycle, then go to WAIT.
  - WAIT: hold every eng_* output stable. On eng_done:
    - remaining -= chunk
    - offset += chunk
    - chunk_count += 1
    - if new remaining==0, go to DONE; otherwise load the next chunk size and go to LAUNCH.
  - DONE: ap_done=ap_ready=1 for one cycle, then go to IDLE.
- eng_done seen in IDLE, LAUNCH or DONE is ignored.
- Address arithmetic is unsigned modulo 2^C_ADDR_WIDTH; no boundary check.
- ap_idle register:
  - cleared the cycle after start_pulse is accepted;
  - set the cycle after ap_done.
  - Hence ap_done and ap_idle are never both high.
- Latency:
  - start edge at cycle T → eng_start at T+1.
  - eng_done at cycle W → next eng_start, or ap_done, at W+1 → ap_idle high at W+2.
  - Zero-length job: ap_done at T+1, no eng_start.
- ap_start held high after completion: no relaunch until it falls and rises again.
- Reset mid-job: immediate return to reset values; the engine is reset by the same areset; no ap_done is issued.
- Last chunk: the remainder when length is not a multiple of C_MAX_CHUNK_BYTES; always a multiple of 4.

Decomposition:
- Shared package kernel_prueba_pkg holds:
  - state enum: IDLE, LAUNCH, WAIT, DONE;
  - LP_BYTES_PER_WORD=4;
  - default chunk-size constant.
- One natural sub-module, kernel_prueba_ap_ctrl, owns:
  - start edge detection;
  - the ap_idle register;
  - ap_done/ap_ready generation from a done request.
- The FSM and counters stay in the top module.

Test Plan:
- in1=2048, base=0x1000, in2=7, max=4096, engine model with done 20 cycles after start:
  - required chunks (offset, size): (0x1000,4096), (0x2000,4096);
  - eng_constant=7; chunk_count=2; exactly one ap_done; ap_idle returns high one cycle after it.
- in1=1500 (6000 B), max=4096 → chunks 4096 then 1904 at base+0x1000; chunk_count=2.
- in1=0 → no eng_start; ap_done pulse one cycle after the start edge; chunk_count=0.
- Second ap_start edge and a spurious eng_done injected while in LAUNCH → both ignored; chunk sequence unchanged.
- ap_start held high for 100 cycles across job completion → exactly one job; a later 0→1 edge starts a new job with freshly latched in1/in2.
- areset asserted during the WAIT of chunk 2 → next cycle: all outputs at reset values, ap_idle=1, no ap_done. A new start then runs a complete job.
